// File: rtl/jtsdram_chk_if.sv
// SDRAM read-port bundle between the checker (master) and the SDRAM arbiter (slave).
interface jtsdram_chk_if #(
    parameter int unsigned AW = 22
);
    logic [AW-1:0] ba_addr;
    logic          ba_rd;
    logic          ba_ack;
    logic          ba_rdy;
    logic [15:0]   data_read;

    modport master (
        output ba_addr, ba_rd,
        input  ba_ack, ba_rdy, data_read
    );

    modport slave (
        input  ba_addr, ba_rd,
        output ba_ack, ba_rdy, data_read
    );
endinterface

// File: rtl/jtsdram_chk.sv
// Walks SDRAM addresses, compares each word against addr^KEY and flags errors;
// the sticky flag is cleared at every line start and quiesces during downloads.
module jtsdram_chk #(
    parameter int unsigned    AW   = 22,
    parameter logic [AW-1:0]  STEP = AW'(22'd1),
    parameter logic [15:0]    KEY  = 16'h5A3C,
    parameter logic [7:0]     TOUT = 8'd255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               dwnld_busy,
    input  logic               LHBL,
    jtsdram_chk_if.master      bus,
    output logic               bad,
    output logic [7:0]         err_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CMP} state_t;

    state_t      state;
    logic [7:0]  tcnt;
    logic [15:0] rd_data;
    logic        lhbl_l;
    logic        armed;
    logic        discard;

    logic [15:0] exp_c;
    logic        line_start_c;
    logic        hold_c;
    logic        timeout_c;
    logic        mismatch_c;
    logic        err_ev_c;

    assign exp_c        = 16'(bus.ba_addr) ^ KEY;
    assign line_start_c = LHBL & ~lhbl_l;
    assign hold_c       = dwnld_busy | discard;
    assign timeout_c    = (state == WAIT) && !bus.ba_rdy && (tcnt == TOUT - 8'd1);
    assign mismatch_c   = (state == CMP) && (rd_data != exp_c);
    assign err_ev_c     = (timeout_c | mismatch_c) & ~hold_c;

    // armed delays the first request after reset by one enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.ba_rd   <= 1'b0;
            bus.ba_addr <= '0;
            bad         <= 1'b0;
            err_cnt     <= 8'd0;
            tcnt        <= 8'd0;
            rd_data     <= 16'd0;
            lhbl_l      <= 1'b0;
            armed       <= 1'b0;
            discard     <= 1'b0;
        end else begin
            lhbl_l <= LHBL;
            armed  <= armed | en;

            // an error on the line-start cycle wins over the clear
            if (!dwnld_busy) begin
                if (err_ev_c) begin
                    bad <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end else if (line_start_c) begin
                    bad <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (dwnld_busy) begin
                        bus.ba_addr <= '0;
                    end else if (en && armed) begin
                        state     <= REQ;
                        bus.ba_rd <= 1'b1;
                    end
                end
                REQ: begin
                    if (dwnld_busy) discard <= 1'b1;
                    if (bus.ba_ack) begin
                        bus.ba_rd <= 1'b0;
                        tcnt      <= 8'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (dwnld_busy) discard <= 1'b1;
                    if (bus.ba_rdy) begin
                        rd_data <= bus.data_read;
                        state   <= CMP;
                    end else if (timeout_c) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                CMP: begin
                    bus.ba_addr <= bus.ba_addr + STEP;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtsdram_chk.sv
// Directed bench for jtsdram_chk: reads, mismatches, line clears, timeout,
// download quiescing, saturation, address wrap and asynchronous reset.
module tb_jtsdram_chk;

    localparam int unsigned AW  = 10;
    localparam logic [15:0] KEY = 16'h5A3C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          dwnld_busy = 1'b0;
    logic          LHBL = 1'b0;
    logic          bad;
    logic [7:0]    err_cnt;

    int total = 0;
    int nbad  = 0;

    jtsdram_chk_if #(.AW(AW)) bus ();

    jtsdram_chk #(
        .AW   (AW),
        .STEP (10'd1),
        .KEY  (KEY),
        .TOUT (8'd255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dwnld_busy (dwnld_busy),
        .LHBL       (LHBL),
        .bus        (bus),
        .bad        (bad),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_data(input logic [AW-1:0] a);
        return 16'(a) ^ KEY;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // bounded wait for a read request
    task automatic wait_rd(input string name);
        int n;
        n = 0;
        while (bus.ba_rd !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        total++;
        if (bus.ba_rd !== 1'b1) begin
            nbad++;
            $display("FAIL %s wait_rd: ba_rd=%b required 1 within 20 cycles", name, bus.ba_rd);
        end
    endtask

    task automatic ack_after(input int n);
        repeat (n) tick;
        bus.ba_ack = 1'b1;
        tick;
        bus.ba_ack = 1'b0;
    endtask

    task automatic rdy_after(input int n, input logic [15:0] d);
        repeat (n) tick;
        bus.ba_rdy    = 1'b1;
        bus.data_read = d;
        tick;
        bus.ba_rdy    = 1'b0;
        bus.data_read = 16'h0000;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) tick;
        total += 4;
        if (bus.ba_rd !== 1'b0)      begin nbad++; $display("FAIL reset ba_rd: got %b want 0", bus.ba_rd); end
        if (bus.ba_addr !== 10'd0)   begin nbad++; $display("FAIL reset ba_addr: got %0d want 0", bus.ba_addr); end
        if (bad !== 1'b0)            begin nbad++; $display("FAIL reset bad: got %b want 0", bad); end
        if (err_cnt !== 8'd0)        begin nbad++; $display("FAIL reset err_cnt: got %0d want 0", err_cnt); end
        rst_n = 1'b1;
        en    = 1'b1;
        tick;
        total++;
        if (bus.ba_rd !== 1'b0) begin nbad++; $display("FAIL first_edge ba_rd: got %b want 0", bus.ba_rd); end
        tick;
        total += 2;
        if (bus.ba_rd !== 1'b1)    begin nbad++; $display("FAIL second_edge ba_rd: got %b want 1", bus.ba_rd); end
        if (bus.ba_addr !== 10'd0) begin nbad++; $display("FAIL second_edge ba_addr: got %0d want 0", bus.ba_addr); end
    endtask

    task automatic test_good_read;
        // stray rdy while in REQ must be ignored
        bus.ba_rdy = 1'b1; bus.data_read = 16'h0000;
        tick;
        bus.ba_rdy = 1'b0;
        total++;
        if (bus.ba_rd !== 1'b1) begin nbad++; $display("FAIL stray_rdy ba_rd: got %b want 1", bus.ba_rd); end
        ack_after(2);
        rdy_after(3, 16'h5A3C);
        tick;
        total += 4;
        if (bad !== 1'b0)          begin nbad++; $display("FAIL good bad: got %b want 0", bad); end
        if (err_cnt !== 8'd0)      begin nbad++; $display("FAIL good err_cnt: got %0d want 0", err_cnt); end
        if (bus.ba_addr !== 10'd1) begin nbad++; $display("FAIL good ba_addr: got %0d want 1", bus.ba_addr); end
        if (bus.ba_rd !== 1'b0)    begin nbad++; $display("FAIL good idle ba_rd: got %b want 0", bus.ba_rd); end
        tick;
        total++;
        if (bus.ba_rd !== 1'b1) begin nbad++; $display("FAIL back_to_back ba_rd: got %b want 1", bus.ba_rd); end
    endtask

    task automatic test_mismatch_line;
        ack_after(0);
        rdy_after(0, 16'h0000);
        tick;
        total += 3;
        if (bad !== 1'b1)          begin nbad++; $display("FAIL mismatch bad: got %b want 1", bad); end
        if (err_cnt !== 8'd1)      begin nbad++; $display("FAIL mismatch err_cnt: got %0d want 1", err_cnt); end
        if (bus.ba_addr !== 10'd2) begin nbad++; $display("FAIL mismatch ba_addr: got %0d want 2", bus.ba_addr); end
        tick;
        LHBL = 1'b1;
        tick;
        total++;
        if (bad !== 1'b0) begin nbad++; $display("FAIL line_clear bad: got %b want 0", bad); end
        LHBL = 1'b0;
        tick;
        // mismatch on the same edge as a line start
        wait_rd("err_wins");
        ack_after(0);
        rdy_after(0, 16'h0000);
        LHBL = 1'b1;
        tick;
        total += 2;
        if (bad !== 1'b1)     begin nbad++; $display("FAIL err_wins bad: got %b want 1", bad); end
        if (err_cnt !== 8'd2) begin nbad++; $display("FAIL err_wins err_cnt: got %0d want 2", err_cnt); end
        LHBL = 1'b0;
        tick;
        LHBL = 1'b1;
        tick;
        total++;
        if (bad !== 1'b0) begin nbad++; $display("FAIL second_clear bad: got %b want 0", bad); end
        LHBL = 1'b0;
    endtask

    task automatic test_timeout_precedence;
        wait_rd("precedence");
        ack_after(0);
        repeat (254) tick;
        total++;
        if (bus.ba_rd !== 1'b0 || bad !== 1'b0) begin
            nbad++; $display("FAIL pre_timeout ba_rd/bad: got %b/%b want 0/0", bus.ba_rd, bad);
        end
        rdy_after(0, exp_data(10'd3));
        tick;
        total += 3;
        if (bad !== 1'b0)          begin nbad++; $display("FAIL precedence bad: got %b want 0", bad); end
        if (err_cnt !== 8'd2)      begin nbad++; $display("FAIL precedence err_cnt: got %0d want 2", err_cnt); end
        if (bus.ba_addr !== 10'd4) begin nbad++; $display("FAIL precedence ba_addr: got %0d want 4", bus.ba_addr); end
    endtask

    task automatic test_timeout;
        wait_rd("timeout");
        ack_after(0);
        repeat (254) tick;
        total++;
        if (bad !== 1'b0) begin nbad++; $display("FAIL timeout_early bad: got %b want 0", bad); end
        tick;
        total += 4;
        if (bad !== 1'b1)          begin nbad++; $display("FAIL timeout bad: got %b want 1", bad); end
        if (err_cnt !== 8'd3)      begin nbad++; $display("FAIL timeout err_cnt: got %0d want 3", err_cnt); end
        if (bus.ba_addr !== 10'd4) begin nbad++; $display("FAIL timeout ba_addr: got %0d want 4", bus.ba_addr); end
        if (bus.ba_rd !== 1'b0)    begin nbad++; $display("FAIL timeout idle ba_rd: got %b want 0", bus.ba_rd); end
        tick;
        total++;
        if (bus.ba_rd !== 1'b1) begin nbad++; $display("FAIL timeout retry ba_rd: got %b want 1", bus.ba_rd); end
        LHBL = 1'b1;
        tick;
        LHBL = 1'b0;
        total++;
        if (bad !== 1'b0) begin nbad++; $display("FAIL timeout clear bad: got %b want 0", bad); end
    endtask

    task automatic test_download;
        int rd_seen;
        wait_rd("download");
        ack_after(0);
        dwnld_busy = 1'b1;
        rdy_after(1, 16'hDEAD);
        tick;
        total += 3;
        if (bad !== 1'b0)          begin nbad++; $display("FAIL dwnld bad: got %b want 0", bad); end
        if (err_cnt !== 8'd3)      begin nbad++; $display("FAIL dwnld err_cnt: got %0d want 3", err_cnt); end
        if (bus.ba_addr !== 10'd5) begin nbad++; $display("FAIL dwnld cmp ba_addr: got %0d want 5", bus.ba_addr); end
        tick;
        total++;
        if (bus.ba_addr !== 10'd0) begin nbad++; $display("FAIL dwnld idle ba_addr: got %0d want 0", bus.ba_addr); end
        rd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus.ba_rd === 1'b1) rd_seen++;
        end
        total++;
        if (rd_seen !== 0) begin nbad++; $display("FAIL dwnld quiet: ba_rd high %0d cycles want 0", rd_seen); end
        dwnld_busy = 1'b0;
        tick;
        total += 2;
        if (bus.ba_rd !== 1'b1)    begin nbad++; $display("FAIL dwnld resume ba_rd: got %b want 1", bus.ba_rd); end
        if (bus.ba_addr !== 10'd0) begin nbad++; $display("FAIL dwnld resume ba_addr: got %0d want 0", bus.ba_addr); end
    endtask

    task automatic test_saturation;
        logic [AW-1:0] a;
        a = 10'd0;
        for (int i = 1; i <= 300; i++) begin
            wait_rd("sat");
            ack_after(0);
            rdy_after(0, exp_data(a) ^ 16'hFFFF);
            tick;
            a = a + 10'd1;
            if (i == 100) begin
                total++;
                if (err_cnt !== 8'd103) begin nbad++; $display("FAIL sat mid err_cnt: got %0d want 103", err_cnt); end
            end
        end
        total += 3;
        if (err_cnt !== 8'hFF)       begin nbad++; $display("FAIL sat err_cnt: got %0d want 255", err_cnt); end
        if (bad !== 1'b1)            begin nbad++; $display("FAIL sat bad: got %b want 1", bad); end
        if (bus.ba_addr !== 10'd300) begin nbad++; $display("FAIL sat ba_addr: got %0d want 300", bus.ba_addr); end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] a;
        a = 10'd300;
        while (a != 10'd1023) begin
            wait_rd("wrap_walk");
            ack_after(0);
            rdy_after(0, exp_data(a));
            tick;
            a = a + 10'd1;
        end
        total++;
        if (bus.ba_addr !== 10'd1023) begin nbad++; $display("FAIL wrap top ba_addr: got %0d want 1023", bus.ba_addr); end
        wait_rd("wrap");
        ack_after(0);
        rdy_after(0, 16'h03FF ^ KEY);
        tick;
        total += 2;
        if (bus.ba_addr !== 10'd0) begin nbad++; $display("FAIL wrap ba_addr: got %0d want 0", bus.ba_addr); end
        if (err_cnt !== 8'hFF)     begin nbad++; $display("FAIL wrap err_cnt: got %0d want 255", err_cnt); end
    endtask

    task automatic test_async_reset;
        wait_rd("async");
        ack_after(0);
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.ba_rd !== 1'b0)    begin nbad++; $display("FAIL async ba_rd: got %b want 0", bus.ba_rd); end
        if (bad !== 1'b0)          begin nbad++; $display("FAIL async bad: got %b want 0", bad); end
        if (err_cnt !== 8'd0)      begin nbad++; $display("FAIL async err_cnt: got %0d want 0", err_cnt); end
        if (bus.ba_addr !== 10'd0) begin nbad++; $display("FAIL async ba_addr: got %0d want 0", bus.ba_addr); end
        tick;
        rst_n = 1'b1;
        tick;
        total++;
        if (bus.ba_rd !== 1'b0) begin nbad++; $display("FAIL async first_edge ba_rd: got %b want 0", bus.ba_rd); end
    endtask

    initial begin
        bus.ba_ack    = 1'b0;
        bus.ba_rdy    = 1'b0;
        bus.data_read = 16'h0000;
        test_reset;
        test_good_read;
        test_mismatch_line;
        test_timeout_precedence;
        test_timeout;
        test_download;
        test_saturation;
        test_wrap;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule

// File: doc/jtsdram_chk.md
JTSDRAM_CHK -- requirements
Module: jtsdram_chk

Interface
REQ-001 Parameter: AW, 22, SDRAM word-address width.
REQ-002 Parameter: STEP, 22'd1, address increment between consecutive reads.
REQ-003 Parameter: KEY, 16'h5A3C, XOR key for the expected-data pattern.
REQ-004 Parameter: TOUT, 8'd255, maximum cycles from ba_ack to ba_rdy.
REQ-005 Ports: clk  in  1  system clock; all logic on rising edge.
REQ-006 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-007 Ports: en  in  1  checker enable.
REQ-008 Ports: dwnld_busy  in  1  download in progress; checker quiesces.
REQ-009 Ports: LHBL  in  1  horizontal blank, active low; rising edge marks line start.
REQ-010 Ports: ba_addr  out  AW  read word address.
REQ-011 Ports: ba_rd  out  1  read request.
REQ-012 Ports: ba_ack  in  1  request accepted, one-cycle pulse.
REQ-013 Ports: ba_rdy  in  1  data_read valid, one-cycle pulse.
REQ-014 Ports: data_read  in  16  SDRAM read data.
REQ-015 Ports: bad  out  1  sticky error flag, cleared at each line start; feeds the sound-alarm stage.
REQ-016 Ports: err_cnt  out  8  saturating error count.

Function
REQ-017 Expected data for address A SHALL be A[15:0] ^ KEY.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, CMP.
REQ-019 IDLE->REQ SHALL occur when en=1 and dwnld_busy=0; otherwise the FSM stays in IDLE.
REQ-020 In REQ, ba_rd SHALL be 1 with ba_addr stable until ba_ack; ba_ack moves the FSM to WAIT and clears the timeout counter.
REQ-021 In WAIT, ba_rdy SHALL capture data_read and move the FSM to CMP.
REQ-022 In WAIT, after TOUT cycles without ba_rdy, the checker SHALL set bad, increment err_cnt and go to IDLE without advancing ba_addr.
REQ-023 ba_rdy arriving on the timeout cycle SHALL take precedence (normal capture).
REQ-024 CMP SHALL last one cycle and compare captured data to the expected value.
REQ-025 On mismatch, CMP SHALL set bad and increment err_cnt.
REQ-026 CMP SHALL then advance ba_addr by STEP, modulo 2^AW, and return to IDLE.
REQ-027 Read latency SHALL be REQ entry to CMP = 1 + ack wait + rdy wait cycles.
REQ-028 Back-to-back reads SHALL be separated by exactly one IDLE cycle.
REQ-029 err_cnt SHALL saturate at 8'hFF.
REQ-030 LHBL rising edge SHALL be detected against a registered copy of LHBL.
REQ-031 On the detection cycle, bad SHALL be cleared, so downstream logic sampling on that same edge still sees the pre-clear value.
REQ-032 An error in the same cycle as a line-start clear SHALL win: bad=1.
REQ-033 If dwnld_busy rises in REQ or WAIT, the outstanding access SHALL complete (ack/rdy still consumed) but the compare result SHALL be discarded: no bad, no err_cnt change.
REQ-034 While dwnld_busy=1, ba_addr SHALL be forced to 0 on every cycle the FSM is in IDLE.
REQ-035 While dwnld_busy=1, bad and err_cnt SHALL be held.
REQ-036 Dropping en mid-access SHALL NOT abort it; the FSM stops at the next IDLE.
REQ-037 ba_ack received outside REQ, or ba_rdy received outside WAIT, SHALL be ignored.

Reset
REQ-038 rst_n=0 SHALL immediately force: state=IDLE, ba_rd=0, ba_addr=0, bad=0, err_cnt=0, timeout counter=0, registered LHBL=0.
REQ-039 Reset mid-access SHALL abandon the request.
REQ-040 After release, the first ba_rd SHALL occur no earlier than the second clk edge with en=1.

Verification
REQ-041 Good read: en=1, ack after 2 cycles, rdy after 3 with data_read=16'h5A3C at addr 0 -> bad=0, err_cnt=0, ba_addr=1 after CMP.
REQ-042 Mismatch then line start: addr 1 returns 16'h0000 -> bad=1 and err_cnt=1 next cycle; LHBL rise -> bad=0 one cycle later.
REQ-043 Timeout: ack given, rdy withheld 255 cycles -> bad=1, err_cnt+1, ba_addr unchanged, ba_rd reasserted after one IDLE cycle.
REQ-044 Saturation/wrap: 300 forced mismatches -> err_cnt=8'hFF; ba_addr=2^AW-1 with STEP=1 -> next ba_addr=0.
REQ-045 Download mid-WAIT: dwnld_busy=1 then rdy with wrong data -> bad unchanged, ba_addr=0 in IDLE, no ba_rd until dwnld_busy=0.
REQ-046 Async reset in WAIT: rst_n low between edges -> ba_rd=0, bad=0, err_cnt=0 with no clk edge.
